// File: rtl/fsm1_seq_pkg.sv
// Shared definitions for the fsm1_route pulse sequencer: vector word layout,
// state codes and default frame timing.
package fsm1_seq_pkg;

  localparam int IN1_BIT      = 0;
  localparam int IN2_BIT      = 1;
  localparam int RST_BIT      = 2;
  localparam int EXP_OBS0_BIT = 3;
  localparam int EXP_OBS1_BIT = 4;
  localparam int EXP_OUT1_BIT = 5;

  typedef logic [5:0] vec_word_t;
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_PRE  = 3'd1;
  localparam state_t ST_RUN  = 3'd2;
  localparam state_t ST_POST = 3'd3;
  localparam state_t ST_DONE = 3'd4;

  localparam int DEF_DEPTH       = 16;
  localparam int DEF_PERIOD      = 80;
  localparam int DEF_IN_TICK     = 40;
  localparam int DEF_CLK_TICK    = 78;
  localparam int DEF_PW          = 2;
  localparam int DEF_SAMPLE_TICK = 30;
  localparam int DEF_IDLE_FRAMES = 20;

  // Expected observation in the same order as the sampled pins {out1, obs1, obs0}.
  function automatic logic [2:0] exp_fields(input vec_word_t v);
    return {v[EXP_OUT1_BIT], v[EXP_OBS1_BIT], v[EXP_OBS0_BIT]};
  endfunction

endpackage

// File: rtl/fsm1_seq_frame_timer.sv
// Frame tick counter with frame-end/sample strobes and pulse-window decode
// of the upcoming tick, so the top can register its pins without lag.
module fsm1_seq_frame_timer
  import fsm1_seq_pkg::*;
#(
  parameter int PERIOD      = DEF_PERIOD,
  parameter int IN_TICK     = DEF_IN_TICK,
  parameter int CLK_TICK    = DEF_CLK_TICK,
  parameter int PW          = DEF_PW,
  parameter int SAMPLE_TICK = DEF_SAMPLE_TICK
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic frame_end,
  output logic sample,
  output logic clk_win_nxt,
  output logic in_win_nxt
);

  localparam int TW = $clog2(PERIOD);
  localparam logic [TW-1:0] LAST   = TW'(PERIOD - 1);
  localparam logic [TW-1:0] SMP    = TW'(SAMPLE_TICK);
  localparam logic [TW-1:0] CLK_LO = TW'(CLK_TICK);
  localparam logic [TW-1:0] CLK_HI = TW'(CLK_TICK + PW - 1);
  localparam logic [TW-1:0] IN_LO  = TW'(IN_TICK);
  localparam logic [TW-1:0] IN_HI  = TW'(IN_TICK + PW - 1);

  logic [TW-1:0] tick;
  logic [TW-1:0] tick_nxt;

  always_comb begin
    tick_nxt = '0;
    if (!clear && en && (tick != LAST)) begin
      tick_nxt = tick + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick <= '0;
    end else begin
      tick <= tick_nxt;
    end
  end

  assign frame_end   = en && (tick == LAST);
  assign sample      = en && (tick == SMP);
  assign clk_win_nxt = (tick_nxt >= CLK_LO) && (tick_nxt <= CLK_HI);
  assign in_win_nxt  = (tick_nxt >= IN_LO) && (tick_nxt <= IN_HI);

endmodule

// File: rtl/fsm1_pulse_sequencer.sv
// On-chip stimulus/check sequencer for fsm1_route: replays a stored vector list
// as framed pulse trains and counts observation mismatches.
//
// state | meaning
// IDLE  | waiting for start; vector writes accepted
// PRE   | clock-only lead-in frames
// RUN   | one frame per vector, input pulses driven
// POST  | clock-only trailing frames; last vector checked in the first one
// DONE  | single completion cycle, then back to IDLE
module fsm1_pulse_sequencer
  import fsm1_seq_pkg::*;
#(
  parameter  int DEPTH       = DEF_DEPTH,
  parameter  int PERIOD      = DEF_PERIOD,
  parameter  int IN_TICK     = DEF_IN_TICK,
  parameter  int CLK_TICK    = DEF_CLK_TICK,
  parameter  int PW          = DEF_PW,
  parameter  int SAMPLE_TICK = DEF_SAMPLE_TICK,
  parameter  int IDLE_FRAMES = DEF_IDLE_FRAMES,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic          GCLK_Pad,
  input  logic          reset_Pad,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [5:0]    wr_data,
  input  logic [AW:0]   num_vec,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          dut_clk,
  output logic          dut_input1,
  output logic          dut_input2,
  output logic          dut_reset,
  input  logic          dut_obs0,
  input  logic          dut_obs1,
  input  logic          dut_out1,
  output logic [AW:0]   mismatch_cnt,
  output logic [AW-1:0] first_fail_idx,
  output logic          first_fail_valid
);

  localparam int FW = $clog2(((IDLE_FRAMES > DEPTH) ? IDLE_FRAMES : DEPTH) + 1);
  localparam logic [FW-1:0] IDLE_LAST = FW'(IDLE_FRAMES - 1);
  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

  state_t        state, state_nxt;
  logic [FW-1:0] frames_left, frames_nxt;
  logic [AW-1:0] vec_idx, idx_nxt, chk_idx;
  logic [AW:0]   n_vec;
  logic          chk_pend;
  logic          start_acc, busy_nxt, run_nxt;
  logic          frame_end, sample, clk_win_nxt, in_win_nxt;
  vec_word_t     vec_mem [DEPTH];
  vec_word_t     vec_nxt;
  logic [2:0]    obs;

  assign start_acc = start && (state == ST_IDLE);
  assign busy_nxt  = (state_nxt == ST_PRE) || (state_nxt == ST_RUN) || (state_nxt == ST_POST);
  assign run_nxt   = (state_nxt == ST_RUN);
  assign vec_nxt   = vec_mem[idx_nxt];
  assign obs       = {dut_out1, dut_obs1, dut_obs0};

  fsm1_seq_frame_timer #(
    .PERIOD      (PERIOD),
    .IN_TICK     (IN_TICK),
    .CLK_TICK    (CLK_TICK),
    .PW          (PW),
    .SAMPLE_TICK (SAMPLE_TICK)
  ) u_timer (
    .clk         (GCLK_Pad),
    .rst         (reset_Pad),
    .en          (busy),
    .clear       (start_acc),
    .frame_end   (frame_end),
    .sample      (sample),
    .clk_win_nxt (clk_win_nxt),
    .in_win_nxt  (in_win_nxt)
  );

  // frames_left counts down to the terminal frame of the current phase.
  always_comb begin
    state_nxt  = state;
    frames_nxt = frames_left;
    idx_nxt    = vec_idx;
    case (state)
      ST_IDLE: if (start) begin
        state_nxt  = ST_PRE;
        frames_nxt = IDLE_LAST;
        idx_nxt    = '0;
      end
      ST_PRE: if (frame_end) begin
        if (frames_left != '0) begin
          frames_nxt = frames_left - 1'b1;
        end else if (n_vec == '0) begin
          state_nxt  = ST_POST;
          frames_nxt = IDLE_LAST;
        end else begin
          state_nxt  = ST_RUN;
          frames_nxt = FW'(n_vec - 1'b1);
        end
      end
      ST_RUN: if (frame_end) begin
        idx_nxt = vec_idx + 1'b1;
        if (frames_left != '0) begin
          frames_nxt = frames_left - 1'b1;
        end else begin
          state_nxt  = ST_POST;
          frames_nxt = IDLE_LAST;
        end
      end
      ST_POST: if (frame_end) begin
        if (frames_left != '0) frames_nxt = frames_left - 1'b1;
        else                   state_nxt  = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge GCLK_Pad) begin
    if (reset_Pad) begin
      state       <= ST_IDLE;
      frames_left <= '0;
      vec_idx     <= '0;
      n_vec       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      dut_clk     <= 1'b0;
      dut_input1  <= 1'b0;
      dut_input2  <= 1'b0;
      dut_reset   <= 1'b0;
    end else begin
      state       <= state_nxt;
      frames_left <= frames_nxt;
      vec_idx     <= idx_nxt;
      busy        <= busy_nxt;
      if (start_acc) begin
        n_vec <= (num_vec > DEPTH_W) ? DEPTH_W : num_vec;
        done  <= 1'b0;
      end else if (state_nxt == ST_DONE) begin
        done <= 1'b1;
      end
      dut_clk    <= busy_nxt && clk_win_nxt;
      dut_input1 <= run_nxt && in_win_nxt && vec_nxt[IN1_BIT];
      dut_input2 <= run_nxt && in_win_nxt && vec_nxt[IN2_BIT];
      dut_reset  <= run_nxt && in_win_nxt && vec_nxt[RST_BIT];
    end
  end

  always_ff @(posedge GCLK_Pad) begin
    if (wr_en && !busy) begin
      vec_mem[wr_addr] <= wr_data;
    end
  end

  // Vector k is judged one frame later, once the DUT has been clocked with it.
  always_ff @(posedge GCLK_Pad) begin
    if (reset_Pad || start_acc) begin
      chk_pend         <= 1'b0;
      chk_idx          <= '0;
      mismatch_cnt     <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      if (sample && chk_pend) begin
        chk_pend <= 1'b0;
        if (obs != exp_fields(vec_mem[chk_idx])) begin
          if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
          if (!first_fail_valid) begin
            first_fail_idx   <= chk_idx;
            first_fail_valid <= 1'b1;
          end
        end
      end
      if ((state == ST_RUN) && frame_end) begin
        chk_pend <= 1'b1;
        chk_idx  <= vec_idx;
      end
    end
  end

endmodule

// File: tb/tb_fsm1_pulse_sequencer.sv
// Directed + randomized bench for fsm1_pulse_sequencer; expected pin waveforms
// and check results come from frame arithmetic over a model vector array.
module tb_fsm1_pulse_sequencer;

  localparam int DEPTH       = 16;
  localparam int PERIOD      = 80;
  localparam int IN_TICK     = 40;
  localparam int CLK_TICK    = 78;
  localparam int PW          = 2;
  localparam int SAMPLE_TICK = 30;
  localparam int IDLE_FRAMES = 20;

  logic       clk = 1'b0;
  logic       reset_Pad;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [5:0] wr_data;
  logic [4:0] num_vec;
  logic       start;
  logic       busy, done, dut_clk, dut_input1, dut_input2, dut_reset;
  logic [2:0] obs;
  logic [4:0] mismatch_cnt;
  logic [3:0] first_fail_idx;
  logic       first_fail_valid;

  logic [5:0] mem_m [DEPTH];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fsm1_pulse_sequencer dut (
    .GCLK_Pad         (clk),
    .reset_Pad        (reset_Pad),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .num_vec          (num_vec),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .dut_clk          (dut_clk),
    .dut_input1       (dut_input1),
    .dut_input2       (dut_input2),
    .dut_reset        (dut_reset),
    .dut_obs0         (obs[0]),
    .dut_obs1         (obs[1]),
    .dut_out1         (obs[2]),
    .mismatch_cnt     (mismatch_cnt),
    .first_fail_idx   (first_fail_idx),
    .first_fail_valid (first_fail_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
    if (errors > 40) begin
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({busy, done, dut_clk, dut_input1, dut_input2, dut_reset,
                mismatch_cnt, first_fail_idx, first_fail_valid});
  endfunction

  task automatic write_vec(input int addr, input logic [5:0] data);
    wr_en   = 1'b1;
    wr_addr = 4'(addr);
    wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    mem_m[addr] = data;
  endtask

  // mode: 0 = DUT answers as expected, 1 = random answers, 2 = all-zero answers.
  // inj_c: cycle for a stray start+write while busy; abort_c: cycle to assert reset.
  task automatic run_seq(input int nv, input int mode, input int inj_c, input int abort_c);
    int n, total, exp_mm, exp_ff;
    logic [2:0] resp [DEPTH];
    n      = (nv > DEPTH) ? DEPTH : nv;
    total  = PERIOD * (2 * IDLE_FRAMES + n);
    exp_mm = 0;
    exp_ff = -1;
    for (int k = 0; k < n; k++) begin
      case (mode)
        0:       resp[k] = mem_m[k][5:3];
        1:       resp[k] = 3'($urandom);
        default: resp[k] = 3'b000;
      endcase
      if (resp[k] != mem_m[k][5:3]) begin
        exp_mm++;
        if (exp_ff < 0) exp_ff = k;
      end
    end
    num_vec = 5'(nv);
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < total; c++) begin
      int t, f, k;
      logic [5:0] pe;
      t  = c % PERIOD;
      f  = c / PERIOD;
      k  = f - IDLE_FRAMES;
      pe = 6'b100000;
      if (t >= CLK_TICK && t < CLK_TICK + PW) pe[3] = 1'b1;
      if (k >= 0 && k < n && t >= IN_TICK && t < IN_TICK + PW) pe[2:0] = mem_m[k][2:0];
      check("pins", 32'({busy, done, dut_clk, dut_reset, dut_input2, dut_input1}), 32'(pe));
      if (k >= 1 && k <= n) obs = (t == SAMPLE_TICK) ? resp[k-1] : ~resp[k-1];
      else                  obs = 3'($urandom);
      if (c == inj_c) begin
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 4'($urandom);
        wr_data = 6'($urandom);
      end else begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      if (c == abort_c) begin
        reset_Pad = 1'b1;
        @(negedge clk);
        reset_Pad = 1'b0;
        check("abort_outs", all_outs(), 32'h0);
        return;
      end
      @(negedge clk);
    end
    check("end_flags", 32'({busy, done, dut_clk, dut_reset, dut_input2, dut_input1}), 32'h10);
    check("mismatch_cnt", 32'(mismatch_cnt), 32'(exp_mm));
    check("first_fail_valid", 32'(first_fail_valid), 32'(exp_ff >= 0));
    if (exp_ff >= 0) check("first_fail_idx", 32'(first_fail_idx), 32'(exp_ff));
    @(negedge clk);
    check("done_sticky", 32'({busy, done}), 32'h1);
  endtask

  initial begin
    reset_Pad = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    num_vec   = '0;
    start     = 1'b0;
    obs       = '0;
    repeat (3) begin
      @(negedge clk);
      check("reset_outs", all_outs(), 32'h0);
    end
    reset_Pad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("idle_outs", all_outs(), 32'h0);
    end

    for (int i = 0; i < DEPTH; i++) write_vec(i, 6'($urandom));

    write_vec(0, 6'b000001);
    run_seq(1, 0, -1, -1);

    write_vec(0, {3'b000, 3'($urandom)});
    write_vec(1, {3'b001, 3'($urandom)});
    write_vec(2, {3'b000, 3'($urandom)});
    run_seq(3, 2, -1, -1);

    run_seq(0, 1, -1, -1);
    run_seq(20, 1, -1, -1);

    run_seq(5, 1, -1, PERIOD * (IDLE_FRAMES + 2) + 10);
    check("abort_idle", 32'({busy, done}), 32'h0);
    run_seq(5, 0, -1, -1);

    run_seq(16, 1, PERIOD * (IDLE_FRAMES + 3) + 41, -1);
    run_seq(16, 0, -1, -1);

    for (int i = 0; i < DEPTH; i++) write_vec(i, 6'($urandom));
    begin
      int nv;
      nv = int'($urandom_range(1, 16));
      run_seq(nv, 1, int'($urandom_range(1, 3000)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
